pixel_layer_scheduler: RTL and testbench

PIXEL_LAYER_SCHEDULER -- requirements
Module: pixel_layer_scheduler

---
 rtl/game_pkg.sv | 15 +
 rtl/sram_pkg.sv | 7 +
 rtl/pixel_layer_scheduler.sv | 157 +++++++++++++++
 tb/tb_pixel_layer_scheduler.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - Game-level object identifiers
// Purpose: identifiers of drawable objects, consumed by the color decoder.
package game_pkg;

  typedef enum logic [2:0] {
    OBJECT_BAR_DIGIT   = 3'd0,
    OBJECT_BAR         = 3'd1,
    OBJECT_CAR1_CIRCLE = 3'd2,
    OBJECT_CAR2_CIRCLE = 3'd3,
    OBJECT_CAR1        = 3'd4,
    OBJECT_CAR2        = 3'd5,
    OBJECT_MAP         = 3'd6
  } ObjectID;

endpackage

// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - Texel SRAM shared definitions
// Purpose: width of an encoded texel color shared by the SRAM path and its consumers.
package sram_pkg;

  localparam int COLOR_WIDTH = 4;

endpackage

// File: rtl/pixel_layer_scheduler.sv
// rtl/pixel_layer_scheduler.sv - Per-pixel layer scan picking the top opaque texel
// Purpose: for each pixel job, read texels of the hit layers in priority order
// (layer 0 first) and report the first opaque one; the map layer always ends
// the scan. One SRAM read is outstanding at most.
// Ports:
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_flush                        synchronous abort, beats every other event
//   i_pix_valid/o_pix_ready        job handshake, i_layer_hit is the job's hit mask
//   o_sram_req/o_sram_layer        texel read request and layer index
//   i_sram_ack/i_sram_data         one-cycle read acknowledge with texel
//   o_out_valid/i_out_ready        result handshake
//   o_object_id/o_encoded_color    winning object and texel
module pixel_layer_scheduler #(
  parameter int          LAYER_NUM        = 7,
  parameter int unsigned TRANSPARENT_CODE = 0,
  parameter int          CW               = sram_pkg::COLOR_WIDTH
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_flush,
  input  logic               i_pix_valid,
  output logic               o_pix_ready,
  input  logic [LAYER_NUM-1:0] i_layer_hit,
  output logic               o_sram_req,
  output logic [2:0]         o_sram_layer,
  input  logic               i_sram_ack,
  input  logic [CW-1:0]      i_sram_data,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output game_pkg::ObjectID  o_object_id,
  output logic [CW-1:0]      o_encoded_color
);

  localparam logic [CW-1:0] TRANSPARENT = CW'(TRANSPARENT_CODE);
  localparam logic [2:0]    LAST_LAYER  = 3'(LAYER_NUM - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;

  state_t                 state, state_next;
  logic [LAYER_NUM-1:0]   pending, pending_next, pending_cleared;
  game_pkg::ObjectID      obj_q, obj_next;
  logic [CW-1:0]          color_q, color_next;
  logic [2:0]             low_idx;

  function automatic game_pkg::ObjectID layer_object(input logic [2:0] layer);
    case (layer)
      3'd0:    return game_pkg::OBJECT_BAR_DIGIT;
      3'd1:    return game_pkg::OBJECT_BAR;
      3'd2:    return game_pkg::OBJECT_CAR1_CIRCLE;
      3'd3:    return game_pkg::OBJECT_CAR2_CIRCLE;
      3'd4:    return game_pkg::OBJECT_CAR1;
      3'd5:    return game_pkg::OBJECT_CAR2;
      default: return game_pkg::OBJECT_MAP;
    endcase
  endfunction

  // Highest-priority pending layer, and the mask with that layer retired.
  // The mask only changes when leaving WAIT, so the index is stable while
  // a request is up.
  always_comb begin
    low_idx         = '0;
    pending_cleared = pending;
    for (int k = LAYER_NUM - 1; k >= 0; k--) begin
      if (pending[k]) low_idx = 3'(k);
    end
    pending_cleared[low_idx] = 1'b0;
  end

  always_comb begin
    state_next   = state;
    pending_next = pending;
    obj_next     = obj_q;
    color_next   = color_q;
    o_pix_ready  = 1'b0;
    o_sram_req   = 1'b0;
    o_sram_layer = '0;
    o_out_valid  = 1'b0;

    case (state)
      IDLE: begin
        o_pix_ready = 1'b1;
        if (i_pix_valid) begin
          pending_next = i_layer_hit;
          if (|i_layer_hit) begin
            state_next = REQ;
          end else begin
            state_next = OUT;
            obj_next   = game_pkg::OBJECT_MAP;
            color_next = TRANSPARENT;
          end
        end
      end

      REQ: begin
        o_sram_req   = 1'b1;
        o_sram_layer = low_idx;
        state_next   = WAIT;
      end

      WAIT: begin
        o_sram_req   = 1'b1;
        o_sram_layer = low_idx;
        if (i_sram_ack) begin
          // The map layer is the backdrop: it wins even when transparent.
          if (i_sram_data != TRANSPARENT || low_idx == LAST_LAYER) begin
            obj_next     = layer_object(low_idx);
            color_next   = i_sram_data;
            pending_next = '0;
            state_next   = OUT;
          end else begin
            pending_next = pending_cleared;
            if (|pending_cleared) begin
              state_next = REQ;
            end else begin
              state_next = OUT;
              obj_next   = game_pkg::OBJECT_MAP;
              color_next = TRANSPARENT;
            end
          end
        end
      end

      OUT: begin
        o_out_valid = 1'b1;
        if (i_out_ready) state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase

    // Flush discards whatever this cycle would have done, including an ack.
    if (i_flush) begin
      state_next   = IDLE;
      pending_next = '0;
      obj_next     = obj_q;
      color_next   = color_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      pending <= '0;
      obj_q   <= game_pkg::OBJECT_MAP;
      color_q <= '0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
      obj_q   <= obj_next;
      color_q <= color_next;
    end
  end

  assign o_object_id     = obj_q;
  assign o_encoded_color = color_q;

endmodule

// File: tb/tb_pixel_layer_scheduler.sv
// tb/tb_pixel_layer_scheduler.sv - Randomized self-checking bench for pixel_layer_scheduler
module tb_pixel_layer_scheduler;
  import game_pkg::*;

  localparam int LN = 7;
  localparam int CW = sram_pkg::COLOR_WIDTH;
  localparam logic [CW-1:0] TC = '0;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic flush = 1'b0, pix_valid = 1'b0, sram_ack = 1'b0, out_ready = 1'b0;
  logic [LN-1:0] layer_hit = '0;
  logic [CW-1:0] sram_data = '0;
  logic pix_ready, sram_req, out_valid;
  logic [2:0] sram_layer;
  ObjectID object_id;
  logic [CW-1:0] color;

  int vectors = 0;
  int errors  = 0;

  ObjectID       layer_obj [LN];
  logic [CW-1:0] texel [LN];
  int            exp_reads [$];
  ObjectID       exp_obj;
  logic [CW-1:0] exp_color;

  always #5 clk = ~clk;

  pixel_layer_scheduler #(.LAYER_NUM(LN), .TRANSPARENT_CODE(0), .CW(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_pix_valid(pix_valid), .o_pix_ready(pix_ready), .i_layer_hit(layer_hit),
    .o_sram_req(sram_req), .o_sram_layer(sram_layer),
    .i_sram_ack(sram_ack), .i_sram_data(sram_data),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_object_id(object_id), .o_encoded_color(color)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Exactly one of the three handshake-side indicators is up in every state.
  always @(negedge clk) check("one_state", $countones({pix_ready, sram_req, out_valid}), 1);

  // Reference: scan hit layers in priority order; first opaque texel wins,
  // the last layer wins unconditionally; no winner means map/transparent.
  function automatic void model(input logic [LN-1:0] mask);
    bit done = 0;
    exp_reads.delete();
    exp_obj   = OBJECT_MAP;
    exp_color = TC;
    for (int k = 0; k < LN; k++) begin
      if (!done && mask[k]) begin
        exp_reads.push_back(k);
        if (texel[k] != TC || k == LN - 1) begin
          exp_obj   = layer_obj[k];
          exp_color = texel[k];
          done      = 1;
        end
      end
    end
  endfunction

  task automatic randomize_texels();
    for (int k = 0; k < LN; k++)
      texel[k] = ($urandom_range(0, 1) == 0) ? TC : CW'($urandom_range(1, (1 << CW) - 1));
  endtask

  // Runs one job starting just after a negedge with the DUT idle.
  task automatic run_job(input logic [LN-1:0] mask, input int ack_dly, input int ready_dly,
                         input bit stray_ack);
    model(mask);
    check("idle_ready", pix_ready, 1);
    pix_valid = 1'b1;
    layer_hit = mask;
    @(negedge clk);
    pix_valid = 1'b0;
    layer_hit = LN'($urandom);
    for (int i = 0; i < exp_reads.size(); i++) begin
      for (int c = 0; c < 20 && !sram_req; c++) @(negedge clk);
      check("req_seen", sram_req, 1);
      check("req_layer", sram_layer, exp_reads[i]);
      // First request cycle: an ack here must be ignored.
      if (stray_ack) begin
        sram_ack  = 1'b1;
        sram_data = CW'($urandom_range(1, (1 << CW) - 1));
      end
      pix_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      sram_ack = 1'b0;
      for (int d = 0; d < ack_dly; d++) begin
        check("req_held", sram_req, 1);
        check("layer_held", sram_layer, exp_reads[i]);
        @(negedge clk);
      end
      check("req_held", sram_req, 1);
      check("layer_held", sram_layer, exp_reads[i]);
      sram_ack  = 1'b1;
      sram_data = texel[exp_reads[i]];
      @(negedge clk);
      sram_ack  = 1'b0;
      sram_data = CW'($urandom);
    end
    pix_valid = 1'b0;
    for (int c = 0; c < 20 && !out_valid; c++) begin
      check("no_extra_req", sram_req, 0);
      @(negedge clk);
    end
    check("out_valid", out_valid, 1);
    check("object_id", object_id, exp_obj);
    check("color", color, exp_color);
    for (int d = 0; d < ready_dly; d++) begin
      @(negedge clk);
      check("out_held", out_valid, 1);
      check("id_held", object_id, exp_obj);
      check("color_held", color, exp_color);
      check("busy", pix_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("back_idle", pix_ready, 1);
    check("out_dropped", out_valid, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    layer_obj = '{OBJECT_BAR_DIGIT, OBJECT_BAR, OBJECT_CAR1_CIRCLE, OBJECT_CAR2_CIRCLE,
                  OBJECT_CAR1, OBJECT_CAR2, OBJECT_MAP};
    #2 rst_n = 1'b0;
    #1;
    check("rst_pix_ready", pix_ready, 1);
    check("rst_req", sram_req, 0);
    check("rst_layer", sram_layer, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_obj", object_id, OBJECT_MAP);
    check("rst_color", color, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Map only, opaque texel 5.
    randomize_texels();
    texel[6] = 4'h5;
    model(7'b1000000);
    check("pin36_reads", exp_reads.size(), 1);
    check("pin36_obj", exp_obj, OBJECT_MAP);
    check("pin36_color", exp_color, 5);
    run_job(7'b1000000, 0, 0, 0);

    // Layer 0 transparent, layer 4 opaque 3.
    randomize_texels();
    texel[0] = 4'h0;
    texel[4] = 4'h3;
    model(7'b0010001);
    check("pin37_reads", exp_reads.size(), 2);
    check("pin37_second", exp_reads[1], 4);
    check("pin37_obj", exp_obj, OBJECT_CAR1);
    check("pin37_color", exp_color, 3);
    run_job(7'b0010001, 0, 0, 0);

    // Both layers transparent.
    randomize_texels();
    texel[1] = 4'h0;
    texel[2] = 4'h0;
    model(7'b0000110);
    check("pin38_reads", exp_reads.size(), 2);
    check("pin38_obj", exp_obj, OBJECT_MAP);
    check("pin38_color", exp_color, 0);
    run_job(7'b0000110, 0, 0, 1);

    // Zero mask, long ack, long out stall, transparent map.
    run_job(7'b0000000, 0, 2, 0);
    randomize_texels();
    run_job(7'b0001000, 5, 0, 1);
    run_job(7'b0100000, 0, 4, 0);
    texel[0] = 4'h0;
    texel[6] = 4'h0;
    run_job(7'b1000001, 1, 1, 0);

    // Flush in IDLE with a job offered: not accepted.
    flush = 1'b1; pix_valid = 1'b1; layer_hit = 7'b0000001;
    @(negedge clk);
    flush = 1'b0; pix_valid = 1'b0;
    check("flush_idle_ready", pix_ready, 1);
    check("flush_idle_req", sram_req, 0);

    // Flush in WAIT with a same-cycle opaque ack.
    for (int k = 0; k < LN; k++) texel[k] = 4'h7;
    pix_valid = 1'b1; layer_hit = 7'b0000110;
    @(negedge clk);
    pix_valid = 1'b0;
    check("fw_req", sram_req, 1);
    @(negedge clk);
    check("fw_wait", sram_req, 1);
    flush = 1'b1; sram_ack = 1'b1; sram_data = 4'h9;
    @(negedge clk);
    flush = 1'b0; sram_ack = 1'b0;
    check("fw_idle", pix_ready, 1);
    check("fw_req_drop", sram_req, 0);
    for (int c = 0; c < 3; c++) begin
      check("fw_no_out", out_valid, 0);
      @(negedge clk);
    end
    // Pending mask must be gone: only layer 6 is read now.
    texel[6] = 4'h2;
    run_job(7'b1000000, 0, 0, 0);

    // Flush in OUT.
    pix_valid = 1'b1; layer_hit = '0;
    @(negedge clk);
    pix_valid = 1'b0;
    check("fo_out", out_valid, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fo_dropped", out_valid, 0);
    check("fo_idle", pix_ready, 1);

    // Reset mid-read after a job left non-reset output registers.
    texel[0] = 4'h0; texel[4] = 4'h3;
    run_job(7'b0010001, 0, 0, 0);
    pix_valid = 1'b1; layer_hit = 7'b0001000;
    @(negedge clk);
    pix_valid = 1'b0;
    @(negedge clk);
    check("rw_wait", sram_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rw_pix_ready", pix_ready, 1);
    check("rw_req", sram_req, 0);
    check("rw_layer", sram_layer, 0);
    check("rw_out_valid", out_valid, 0);
    check("rw_obj", object_id, OBJECT_MAP);
    check("rw_color", color, 0);
    @(negedge clk);
    rst_n = 1'b1; sram_ack = 1'b1; sram_data = 4'h5;
    @(negedge clk);
    sram_ack = 1'b0;
    check("late_ack_idle", pix_ready, 1);
    check("late_ack_no_out", out_valid, 0);
    check("late_ack_color", color, 0);

    // Randomized jobs.
    for (int j = 0; j < 50; j++) begin
      logic [LN-1:0] m;
      randomize_texels();
      m = ($urandom_range(0, 3) == 0) ? '0 : LN'($urandom);
      run_job(m, $urandom_range(0, 4), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
